// File: rtl/mult_div_unit_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e          : Op field encodings (3'b11x are NOPs and have no name)
//   state_e       : control FSM states
//   ITERATIONS    : shift-add / restoring-divide steps per operation
//   DIV0_QUOTIENT : LO value written by a divide by zero
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  localparam int unsigned ITERATIONS    = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the EX stage and mult_div_unit.
//   Start, Op, Flush, A, B : issue side (driven by the master / EX stage)
//   Hi, Lo, Busy, Done     : result side (driven by the slave / mult_div_unit)
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic             Flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, Flush, A, B,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, Op, Flush, A, B,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// div_step: one restoring-division step (combinational).
//   partial  : {remainder, next dividend bit}, WIDTH+1 bits
//   divisor  : divisor magnitude
//   rem_next : remainder after a successful or restored subtraction
//   q_bit    : quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] diff;

  // partial < 2*divisor always holds, so the top bit of the difference is
  // a clean borrow flag and a non-borrowing result fits in WIDTH bits.
  always_comb begin
    diff     = partial - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and
// MTHI/MTLO writes, sitting beside the ALU in EX.
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : mult_div_unit_if.slave (Start/Op/Flush/A/B in, Hi/Lo/Busy/Done out)
// Optional feature: define MULDIV_FAST_MULT_EN to replace the 32-step
// multiply with a single-cycle '*' (divide stays iterative).
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic         Clk,
  input  logic         Reset_n,
  mult_div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(ITERATIONS);

  state_e             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   mcand;   // multiplicand (mul) or divisor (div) magnitude
  logic               is_div;
  logic               neg_q;   // negate product / quotient at FIN
  logic               neg_r;   // negate remainder at FIN
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     partial;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    op_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    a_neg     = op_signed & bus.A[WIDTH-1];
    b_neg     = op_signed & bus.B[WIDTH-1];
    a_mag     = a_neg ? -bus.A : bus.A;
    b_mag     = b_neg ? -bus.B : bus.B;
  end

  // Shift-add multiply step: add the multiplicand if the multiplier LSB is
  // set, then shift the whole accumulator right by one (carry included).
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mcand};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  assign partial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_next = {rem_next, acc[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .partial  (partial),
    .divisor  (mcand),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    result   = is_div ? {rem_fix, quo_fix} : prod_fix;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Flush) begin
            case (bus.Op)
              OP_MTHI: hi_r <= bus.A;
              OP_MTLO: lo_r <= bus.A;
              OP_MULT, OP_MULTU: begin
                is_div <= 1'b0;
                mcand  <= a_mag;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
                acc    <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
                state  <= FIN;
`else
                acc    <= {{WIDTH{1'b0}}, b_mag};
                count  <= CW'(ITERATIONS - 1);
                state  <= CALC;
`endif
              end
              OP_DIV, OP_DIVU: begin
                is_div <= 1'b1;
                mcand  <= b_mag;
                if (bus.B == '0) begin
                  // Raw A and the fixed quotient go straight to FIN with no
                  // sign fixup, giving Hi=A, Lo=all-ones.
                  acc   <= {bus.A, DIV0_QUOTIENT};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= FIN;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, a_mag};
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  count <= CW'(ITERATIONS - 1);
                  state <= CALC;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.Flush) begin
            state <= IDLE;
          end else begin
            acc   <= is_div ? div_next : mul_next;
            count <= count - 1'b1;
            if (count == '0) state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          if (!bus.Flush) begin
            {hi_r, lo_r} <= result;
            done_r       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Hi   = hi_r;
  assign bus.Lo   = lo_r;
  assign bus.Busy = (state != IDLE);
  assign bus.Done = done_r;

endmodule
